sobel_edge_detect: RTL and testbench
====================================

Name: sobel_edge_detect

Overview:
- Downstream consumer of the Sobel threshold selector.
- Takes the grayscale (Y) pixel stream from the OV5640 capture/convert path and builds a 3x3 window with two line buffers.
- Computes |Gx|+|Gy| and compares it with the user-selected threshold. Emits a binary edge map as RGB565 toward the VGA display path.
- The threshold is re-latched only at frame start, so a key press never tears a frame.

Parameters:
- H_ACT, 640, active pixels per line (line-buffer depth)
- V_ACT, 480, active lines per frame
- THR_RST, 10, threshold value after reset (matches selector reset value)

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  reset
- frame_start  in  1  one-cycle pulse before first pixel of each frame
- pix_valid  in  1  pix_y valid this cycle
- pix_y  in  8  grayscale pixel, raster order
- sobel_yuzhi  in  8  threshold from selector stage
- edge_valid  out  1  edge_bit/edge_rgb valid
- edge_bit  out  1  1 = edge
- edge_rgb  out  16  16'hFFFF if edge_bit else 16'h0000

Interface: reset sys_rst_n, asynchronous, active-low; clock vga_clk. All logic is in the single vga_clk domain.

Behaviour:
- Reset values:
  - edge_valid=0, edge_bit=0, edge_rgb=0.
  - col/row counters=0.
  - Latched threshold thr_q=THR_RST.
  - Pipeline valid bits=0.
  - Line-buffer contents are don't-care; they are masked by the border rule.
- Counters:
  - col increments on each pix_valid and wraps from H_ACT-1 to 0.
  - On wrap, row increments and saturates at V_ACT-1.
- frame_start:
  - Clears col and row to 0 and loads thr_q<=sobel_yuzhi.
  - If frame_start and pix_valid occur in the same cycle, clear first; that pixel is (0,0).
- thr_q is held constant for the whole frame. sobel_yuzhi changes between frame_start pulses are ignored.
- Line buffers:
  - Two H_ACT x 8 rows, written and read at the current col on pix_valid only.
  - Taps are row-2, row-1 and the current pixel.
- Window: the 3x3 register window shifts only on a valid pixel. Gaps in pix_valid (blanking or stalls) freeze the window and counters.
- Sobel arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Gx and Gy are signed 11 bits.
  - mag = |Gx|+|Gy|, unsigned 12 bits, max 2040, no saturation needed.
- Decision: edge = mag > {4'b0,thr_q}, strict greater-than.
- Border rule: the output for input position (r,c) is the window centred at (r-1,c-1). If r<2 or c<2, edge_bit is forced to 0.
- Latency: edge_valid is pix_valid delayed exactly 3 vga_clk cycles. The pipeline is 3 registered stages:
  1. Buffer read / window shift.
  2. Gx/Gy.
  3. Magnitude + compare.
- Output is one-for-one with input pixels, in the same order.
- Reset mid-frame:
  - Everything returns to reset values immediately; no edge_valid pulses follow from pre-reset pixels.
  - The next pixels are treated as row 0 until frame_start.

Decomposition:
- Shared package sobel_pkg holds:
  - H_ACT, V_ACT, COL_W=10, ROW_W=9.
  - PIX_W=8, MAG_W=12.
  - RGB_EDGE=16'hFFFF, RGB_BG=16'h0000.
- One sub-module, sobel_line_buffer: two-row shift RAM.
  - Inputs: en, col, din.
  - Outputs: tap_r1, tap_r2, registered one-cycle read.
- Window, arithmetic, counters and threshold latch stay in sobel_edge_detect.

Test Plan:
- Flat frame, all pix_y=8'd100, threshold 10 → edge_bit=0 for all 640x480 outputs; edge_valid count=307200.
- Vertical step: cols<320 =0, cols>=320 =255, threshold 10 → rows>=2: edge_bit=1 only at output cols 320 and 321 (mag=1020); rows 0-1 and cols 0-1 all 0.
- Horizontal ramp, pix_y=5*col (mod 256 avoided, cols<50 only), mag=40 → thresholds 30/40/50 give edge 1/0/0 (strict >) at interior pixels.
- Threshold changed 10→190 mid-frame → current frame still uses 10; change takes effect only after next frame_start; frame_start coincident with pix_valid → that pixel counted as (0,0).
- Random 1-3 cycle gaps in pix_valid on step image → identical edge_bit sequence to gap-free run; edge_valid always 3 cycles after each pix_valid.
- Assert sys_rst_n low mid-line → outputs 0 next edge, thr_q=10; no stale edge_valid after release; correct output after next frame_start.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, frame geometry and helpers for the Sobel edge path.
package sobel_pkg;
  localparam int H_ACT  = 640;
  localparam int V_ACT  = 480;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;
  localparam int PIX_W  = 8;
  localparam int MAG_W  = 12;
  localparam int GRAD_W = 11;

  localparam logic [15:0] RGB_EDGE = 16'hFFFF;
  localparam logic [15:0] RGB_BG   = 16'h0000;

  // a + 2b + c; worst case 1020 so it always fits in GRAD_W bits
  function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
  endfunction

  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? GRAD_W'(~g + 1'b1) : GRAD_W'(g);
  endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row shift RAM: row-1 and row-2 taps at the current column, read registered one cycle.
// Both rows advance only on en, so blanking gaps leave the taps untouched.
module sobel_line_buffer #(
  parameter int DEPTH = sobel_pkg::H_ACT
) (
  input  logic                        vga_clk,
  input  logic                        sys_rst_n,
  input  logic                        en,
  input  logic [sobel_pkg::COL_W-1:0] col,
  input  logic [sobel_pkg::PIX_W-1:0] din,
  output logic [sobel_pkg::PIX_W-1:0] tap_r1,
  output logic [sobel_pkg::PIX_W-1:0] tap_r2
);
  import sobel_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] row1_mem [DEPTH];
  logic [PIX_W-1:0] row2_mem [DEPTH];
  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] tap_r1_q, tap_r1_d, tap_r2_q, tap_r2_d;

  assign addr = AW'(col);

  // Contents are never reset; the border rule masks whatever is left over.
  always_ff @(posedge vga_clk) begin
    if (en) begin
      row1_mem[addr] <= din;
      row2_mem[addr] <= row1_mem[addr];
    end
  end

  always_comb begin
    tap_r1_d = tap_r1_q;
    tap_r2_d = tap_r2_q;
    if (en) begin
      tap_r1_d = row1_mem[addr];
      tap_r2_d = row2_mem[addr];
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tap_r1_q <= '0;
      tap_r2_q <= '0;
    end else begin
      tap_r1_q <= tap_r1_d;
      tap_r2_q <= tap_r2_d;
    end
  end

  assign tap_r1 = tap_r1_q;
  assign tap_r2 = tap_r2_q;
endmodule

// File: rtl/sobel_edge_detect.sv
// Sobel |Gx|+|Gy| edge detector on a raster Y stream; 3-cycle fixed latency, one output per input pixel.
// Threshold is latched per frame at frame_start so a mid-frame change never tears the picture.
module sobel_edge_detect #(
  parameter int H_ACT   = sobel_pkg::H_ACT,
  parameter int V_ACT   = sobel_pkg::V_ACT,
  parameter int THR_RST = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_y,
  input  logic [7:0]  sobel_yuzhi,
  output logic        edge_valid,
  output logic        edge_bit,
  output logic [15:0] edge_rgb
);
  import sobel_pkg::*;

  logic [COL_W-1:0]         col_q, col_d, cur_col;
  logic [ROW_W-1:0]         row_q, row_d, cur_row;
  logic [PIX_W-1:0]         thr_q, thr_d, thr_cur;
  logic                     v1_q, v1_d, in1_q, in1_d;
  logic [PIX_W-1:0]         pix1_q, pix1_d, thr1_q, thr1_d;
  logic [PIX_W-1:0]         tap_r1, tap_r2;
  logic [2:0][PIX_W-1:0]    new_col, wc0_q, wc0_d, wc1_q, wc1_d;
  logic                     v2_q, v2_d, in2_q, in2_d;
  logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [PIX_W-1:0]         thr2_q, thr2_d;
  logic [MAG_W-1:0]         mag;
  logic                     edge_valid_q, edge_valid_d, edge_bit_q, edge_bit_d;
  logic [15:0]              edge_rgb_q, edge_rgb_d;

  // frame_start clears position before a coincident pixel is placed at (0,0)
  always_comb begin
    cur_col = frame_start ? '0 : col_q;
    cur_row = frame_start ? '0 : row_q;
    thr_cur = frame_start ? sobel_yuzhi : thr_q;
    col_d   = cur_col;
    row_d   = cur_row;
    thr_d   = thr_cur;
    v1_d    = pix_valid;
    pix1_d  = pix1_q;
    in1_d   = in1_q;
    thr1_d  = thr1_q;
    if (pix_valid) begin
      if (cur_col == COL_W'(H_ACT - 1)) begin
        col_d = '0;
        if (cur_row != ROW_W'(V_ACT - 1)) row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
      end
      pix1_d = pix_y;
      in1_d  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      thr1_d = thr_cur;
    end
  end

  sobel_line_buffer #(.DEPTH(H_ACT)) u_line_buffer (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (pix_valid),
    .col       (cur_col),
    .din       (pix_y),
    .tap_r1    (tap_r1),
    .tap_r2    (tap_r2)
  );

  // Index 0 = row-2, 2 = current row; wc0 is column c-2, wc1 is c-1, new_col is c.
  assign new_col = {pix1_q, tap_r1, tap_r2};

  always_comb begin
    wc0_d  = wc0_q;
    wc1_d  = wc1_q;
    v2_d   = v1_q;
    in2_d  = in2_q;
    gx_d   = gx_q;
    gy_d   = gy_q;
    thr2_d = thr2_q;
    if (v1_q) begin
      wc0_d  = wc1_q;
      wc1_d  = new_col;
      gx_d   = signed'(wsum(new_col[0], new_col[1], new_col[2])
                     - wsum(wc0_q[0], wc0_q[1], wc0_q[2]));
      gy_d   = signed'(wsum(wc0_q[2], wc1_q[2], new_col[2])
                     - wsum(wc0_q[0], wc1_q[0], new_col[0]));
      in2_d  = in1_q;
      thr2_d = thr1_q;
    end
  end

  always_comb begin
    mag          = MAG_W'(abs_grad(gx_q)) + MAG_W'(abs_grad(gy_q));
    edge_valid_d = v2_q;
    edge_bit_d   = v2_q && in2_q && (mag > {4'b0, thr2_q});
    edge_rgb_d   = edge_bit_d ? RGB_EDGE : RGB_BG;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      thr_q        <= PIX_W'(THR_RST);
      v1_q         <= 1'b0;
      in1_q        <= 1'b0;
      pix1_q       <= '0;
      thr1_q       <= '0;
      wc0_q        <= '0;
      wc1_q        <= '0;
      v2_q         <= 1'b0;
      in2_q        <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      thr2_q       <= '0;
      edge_valid_q <= 1'b0;
      edge_bit_q   <= 1'b0;
      edge_rgb_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      thr_q        <= thr_d;
      v1_q         <= v1_d;
      in1_q        <= in1_d;
      pix1_q       <= pix1_d;
      thr1_q       <= thr1_d;
      wc0_q        <= wc0_d;
      wc1_q        <= wc1_d;
      v2_q         <= v2_d;
      in2_q        <= in2_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      thr2_q       <= thr2_d;
      edge_valid_q <= edge_valid_d;
      edge_bit_q   <= edge_bit_d;
      edge_rgb_q   <= edge_rgb_d;
    end
  end

  assign edge_valid = edge_valid_q;
  assign edge_bit   = edge_bit_q;
  assign edge_rgb   = edge_rgb_q;
endmodule

// File: tb/tb_sobel_edge_detect.sv
// Bench for sobel_edge_detect on a reduced 16x8 frame: per-pixel reference model plus per-frame edge counts.
module tb_sobel_edge_detect;
  localparam int H   = 16;
  localparam int V   = 8;
  localparam int THR = 10;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_y = '0;
  logic [7:0]  sobel_yuzhi = 8'd10;
  logic        edge_valid, edge_bit;
  logic [15:0] edge_rgb;

  sobel_edge_detect #(.H_ACT(H), .V_ACT(V), .THR_RST(THR)) dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_y       (pix_y),
    .sobel_yuzhi (sobel_yuzhi),
    .edge_valid  (edge_valid),
    .edge_bit    (edge_bit),
    .edge_rgb    (edge_rgb)
  );

  always #5 vga_clk = ~vga_clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_valid = 0;
  int         n_edge = 0;
  bit         exp_q[$];
  logic [2:0] hist = '0;
  int         img[V][H];
  int         mr = 0, mc = 0, mthr = THR;
  logic [7:0] thr_in = 8'd10;

  typedef struct {
    int kind;       // 0 flat 100, 1 vertical step 0->hi at H/2, 2 ramp 5*col
    int hi;
    int thr;
    int exp_edges;
  } vec_t;
  vec_t vecs[10];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix_val(int kind, int hi, int c);
    if (kind == 0) return 100;
    if (kind == 1) return (c < H / 2) ? 0 : hi;
    return 5 * c;
  endfunction

  function automatic bit model_edge(int r, int c, int thr);
    int gx, gy, mag;
    if (r < 2 || c < 2) return 1'b0;
    gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return mag > thr;
  endfunction

  // Inputs change 2 time units after the rising edge; the model tracks what the DUT captures next edge.
  task automatic step(bit fs, bit pv, int y);
    @(posedge vga_clk);
    #2;
    frame_start = fs;
    pix_valid   = pv;
    sobel_yuzhi = thr_in;
    pix_y       = pv ? 8'(y) : 8'($urandom_range(0, 255));
    if (fs) begin
      mr = 0; mc = 0; mthr = thr_in;
    end
    if (pv) begin
      img[mr][mc] = y;
      exp_q.push_back(model_edge(mr, mc, mthr));
      if (mc == H - 1) begin
        mc = 0;
        if (mr < V - 1) mr++;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic run_lines(int kind, int hi, int lines, bit fs_first, bit fs_with_pix, bit gaps, int new_thr);
    n_valid = 0;
    n_edge  = 0;
    if (fs_first && !fs_with_pix) step(1'b1, 1'b0, 0);
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < H; c++) begin
        if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 0);
        if (new_thr >= 0 && r == V / 2 && c == 0) thr_in = 8'(new_thr);
        step(fs_first && fs_with_pix && r == 0 && c == 0, 1'b1, pix_val(kind, hi, c));
      end
    end
    repeat (6) step(1'b0, 1'b0, 0);
  endtask

  task automatic run_frame(int kind, int hi, int thr, bit fs_with_pix, bit gaps, int new_thr);
    thr_in = 8'(thr);
    run_lines(kind, hi, V, 1'b1, fs_with_pix, gaps, new_thr);
  endtask

  task automatic reset_pulse();
    @(posedge vga_clk);
    #2;
    sys_rst_n   = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    exp_q.delete();
    mr = 0; mc = 0; mthr = THR;
    #1;
    check("rst_edge_valid", edge_valid, 0);
    check("rst_edge_bit", edge_bit, 0);
    check("rst_edge_rgb", edge_rgb, 0);
    repeat (2) @(posedge vga_clk);
    #2;
    sys_rst_n = 1'b1;
  endtask

  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) hist <= '0;
    else            hist <= {hist[1:0], pix_valid};
  end

  always @(negedge vga_clk) begin
    if (sys_rst_n) begin
      check("latency_edge_valid", edge_valid, hist[2]);
      if (edge_valid) begin
        n_valid++;
        n_edge += edge_bit;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          bit e;
          e = exp_q.pop_front();
          check("edge_bit", edge_bit, e);
          check("edge_rgb", edge_rgb, e ? 32'hFFFF : 32'h0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0,   10,  0};
    vecs[1] = '{0, 0,   0,   0};
    vecs[2] = '{1, 255, 10,  12};
    vecs[3] = '{1, 255, 255, 12};
    vecs[4] = '{1, 40,  159, 12};
    vecs[5] = '{1, 40,  160, 0};
    vecs[6] = '{2, 0,   30,  84};
    vecs[7] = '{2, 0,   39,  84};
    vecs[8] = '{2, 0,   40,  0};
    vecs[9] = '{2, 0,   50,  0};

    #1;
    sys_rst_n = 1'b0;
    #1;
    check("reset_edge_valid", edge_valid, 0);
    check("reset_edge_bit", edge_bit, 0);
    check("reset_edge_rgb", edge_rgb, 0);
    repeat (2) @(posedge vga_clk);
    #2;
    sys_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].kind, vecs[i].hi, vecs[i].thr, 1'b0, 1'b0, -1);
      check($sformatf("vec%0d_edges", i), n_edge, vecs[i].exp_edges);
      check($sformatf("vec%0d_valids", i), n_valid, H * V);
    end

    // Threshold raised mid-frame: this frame keeps 10, the next one uses 190.
    run_frame(1, 40, 10, 1'b0, 1'b0, 190);
    check("midthr_same_frame", n_edge, 12);
    run_frame(1, 40, 190, 1'b0, 1'b0, -1);
    check("midthr_next_frame", n_edge, 0);

    // frame_start in the same cycle as the first pixel.
    run_frame(1, 255, 10, 1'b1, 1'b0, -1);
    check("fs_with_pix_edges", n_edge, 12);
    check("fs_with_pix_valids", n_valid, H * V);

    // Random pix_valid gaps.
    run_frame(1, 255, 10, 1'b0, 1'b1, -1);
    check("gaps_edges", n_edge, 12);
    check("gaps_valids", n_valid, H * V);

    // Reset mid-line of a frame running with threshold 190.
    thr_in = 8'd190;
    step(1'b1, 1'b0, 0);
    for (int k = 0; k < 3 * H + H / 2 + 3; k++) step(1'b0, 1'b1, pix_val(1, 40, k % H));
    reset_pulse();
    run_lines(1, 40, 3, 1'b0, 1'b0, 1'b0, -1);
    check("post_reset_edges", n_edge, 2);
    check("post_reset_valids", n_valid, 3 * H);
    run_frame(1, 255, 10, 1'b0, 1'b0, -1);
    check("post_reset_frame_edges", n_edge, 12);
    check("post_reset_frame_valids", n_valid, H * V);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
